rom_streamer: RTL and testbench
===============================

# rom_streamer

Sequential reader for the 8×4 lookup ROM. On a start command it walks the ROM from a given start address for a given number of words, wrapping at the top of the address space. Each word is presented on a valid/ready output stream, with a last flag on the final beat. It sits between the ROM and any downstream consumer that needs the table contents as a flow-controlled stream instead of random access.

## Interface
- ADDR_W, 3, ROM address width (DEPTH = 2**ADDR_W = 8)
- DATA_W, 4, ROM word width
- LEN_W, 4, length field width (0..8 meaningful; values > 8 are saturated to 8)

- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  command strobe, sampled only in IDLE
- start_addr  in  ADDR_W  first ROM address to read
- length  in  LEN_W  number of words to stream
- busy  out  1  high from the cycle after an accepted start until the last beat is accepted
- done  out  1  one-cycle pulse after a command completes
- rom_addr  out  ADDR_W  address to the combinational ROM (registered pointer)
- rom_data  in  DATA_W  ROM read data, valid in the same cycle as rom_addr
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_W  output word (registered)
- m_last  out  1  marks the final word of the command

## Operation
- States: IDLE, STREAM. Encoded in 1 bit.
- Reset values: state = IDLE, ptr = 0 (so rom_addr = 0), remaining = 0, busy = 0, done = 0, m_valid = 0, m_data = 0, m_last = 0.
- **IDLE**
  - start = 1 and length != 0: ptr <= start_addr, remaining <= min(length, 8), go to STREAM.
  - start = 1 and length = 0: stay in IDLE and pulse done on the next cycle. No beats are produced.
- **STREAM**
  - Load event: remaining != 0 and (m_valid = 0 or m_ready = 1).
  - On a load event:
    - m_data <= rom_data
    - m_valid <= 1
    - m_last <= (remaining == 1)
    - ptr <= ptr + 1 (modulo 8; 7 wraps to 0)
    - remaining <= remaining − 1
  - Accept with no load (remaining = 0, m_valid = 1, m_ready = 1): m_valid <= 0, m_last <= 0.
  - When that accepted beat has m_last = 1: go to IDLE and pulse done for one cycle.
- busy is high while state = STREAM.
- start is ignored in STREAM; there is no queuing.
- Stream rules:
  - While m_valid = 1 and m_ready = 0, m_data and m_last hold stable.
  - m_valid never drops without an accept.
- Asserting rst_n low mid-stream aborts the command. All outputs return to reset values immediately and no done pulse is generated.

## Timing
- Start sampled at edge N: state = STREAM during cycle N+1. The first word is loaded at edge N+1, so m_valid is high from cycle N+2 (2-cycle latency).
- With m_ready held high, throughput is one word per cycle. An L-word command occupies cycles N+2 … N+1+L.
- The last beat is accepted at edge E. At that edge done <= 1 and busy <= 0, so both change in the cycle after E. done is high for exactly that one cycle.
- A new start is accepted no earlier than the first cycle with busy = 0.

## Configuration
- ROM_STREAMER_PARITY_EN
  - Defined: adds output m_parity (1 bit), the even parity (XOR reduction) of the loaded word. It is registered alongside m_data with identical load and hold behaviour, and resets to 0.
  - Undefined: the port and its logic are absent.

## Structure
- Package rom_stream_pkg holds:
  - ADDR_W, DATA_W, LEN_W, DEPTH constants
  - state enum type (IDLE, STREAM)
- The address pointer and remaining counter naturally form one sub-module, rom_stream_ctr. It provides load, advance with wrap, and a last indication.
- The FSM and output register stay in rom_streamer.

## Test plan
ROM model holds word i = i + 1 (4'h1 … 4'h8).
- start_addr = 0, length = 8, m_ready = 1 → m_data 1,2,…,8 on consecutive cycles starting 2 cycles after start; m_last only on 8; done pulses once on the following cycle.
- start_addr = 6, length = 4 → m_data 7,8,1,2 (wrap); m_last on 2.
- start_addr = 2, length = 3, m_ready toggling 1,0,0,1,0,1 → exactly 3,4,5 delivered once each; m_data/m_last stable while stalled.
- length = 0 → m_valid stays 0; done pulses one cycle after start; busy never rises.
- Second start pulsed mid-command and length = 9 → second start ignored; the length = 9 command produces exactly 8 beats.
- rst_n low during beat 3 of an 8-word command → all outputs 0 immediately; no done; a fresh command afterwards streams correctly from its start_addr.

Source files
------------

// File: rtl/rom_stream_pkg.sv
// Shared constants and FSM state type for the ROM streamer.
package rom_stream_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 4;
    localparam int LEN_W  = 4;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

endpackage

// File: rtl/rom_stream_ctr.sv
// Address pointer and remaining-word counter for the ROM streamer.
// Loads a start address and a saturated length, and advances with wrap at DEPTH.
module rom_stream_ctr
    import rom_stream_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              advance_i,
    output logic [ADDR_W-1:0] ptr_o,
    output logic              last_o,
    output logic              empty_o
);

    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [LEN_W-1:0]  len_sat;

    // Lengths beyond the table size would re-read words, so clamp to one full pass.
    assign len_sat = (len_i > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len_i;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        if (load_i) begin
            ptr_d       = addr_i;
            remaining_d = len_sat;
        end else if (advance_i) begin
            ptr_d       = ptr_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            remaining_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
        end
    end

    assign ptr_o   = ptr_q;
    assign last_o  = (remaining_q == LEN_W'(1));
    assign empty_o = (remaining_q == '0);

endmodule

// File: rtl/rom_streamer.sv
// Streams a run of ROM words onto a valid/ready interface with a last flag.
// Optional ROM_STREAMER_PARITY_EN adds a registered even-parity output m_parity.
module rom_streamer
    import rom_stream_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
`ifdef ROM_STREAMER_PARITY_EN
   ,output logic              m_parity
`endif
);

    state_e            state_q, state_d;
    logic              done_q, done_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic              cmd_load;
    logic              advance;
    logic              ctr_last;
    logic              ctr_empty;

    rom_stream_ctr u_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (cmd_load),
        .addr_i    (start_addr),
        .len_i     (length),
        .advance_i (advance),
        .ptr_o     (rom_addr),
        .last_o    (ctr_last),
        .empty_o   (ctr_empty)
    );

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        valid_d  = valid_q;
        data_d   = data_q;
        last_d   = last_q;
        cmd_load = 1'b0;
        advance  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        cmd_load = 1'b1;
                        state_d  = STREAM;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            STREAM: begin
                // Refill the output register whenever it is empty or being drained.
                if (!ctr_empty && (!valid_q || m_ready)) begin
                    data_d  = rom_data;
                    valid_d = 1'b1;
                    last_d  = ctr_last;
                    advance = 1'b1;
                end else if (valid_q && m_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (last_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign busy    = (state_q == STREAM);
    assign done    = done_q;
    assign m_valid = valid_q;
    assign m_data  = data_q;
    assign m_last  = last_q;

`ifdef ROM_STREAMER_PARITY_EN
    logic parity_q;

    // Loaded on exactly the same condition as data_q, so it holds with it under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (advance) begin
            parity_q <= ^rom_data;
        end
    end

    assign m_parity = parity_q;
`endif

endmodule

// File: tb/tb_rom_streamer.sv
// Directed self-checking bench for rom_streamer against a ROM holding word i = i + 1.
module tb_rom_streamer;
    import rom_stream_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [LEN_W-1:0]  length;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    int checks   = 0;
    int failures = 0;

    rom_streamer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
    );

    assign rom_data = DATA_W'(rom_addr) + 4'd1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".busy"},    32'(busy),    32'd0);
        check({tag, ".done"},    32'(done),    32'd0);
        check({tag, ".valid"},   32'(m_valid), 32'd0);
        check({tag, ".data"},    32'(m_data),  32'd0);
        check({tag, ".last"},    32'(m_last),  32'd0);
        check({tag, ".romaddr"}, 32'(rom_addr), 32'd0);
    endtask

    // Issues one command and scoreboards every accepted beat for a fixed window.
    task automatic run_cmd(input string tag, input int addr, input int len,
                           input bit stall, input bit mid_start);
        int  n_exp;
        int  got;
        int  done_cnt;
        int  last_acc;
        bit  prev_stall;
        logic [DATA_W-1:0] prev_data;
        logic prev_last;
        bit  pat [6];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        n_exp      = (len > DEPTH) ? DEPTH : len;
        got        = 0;
        done_cnt   = 0;
        last_acc   = -10;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;

        start      = 1'b1;
        start_addr = ADDR_W'(addr);
        length     = LEN_W'(len);
        m_ready    = 1'b1;
        cycle();
        start = 1'b0;
        check({tag, ".busy_after_start"},  32'(busy),    32'd1);
        check({tag, ".valid_after_start"}, 32'(m_valid), 32'd0);

        for (int c = 1; c <= 24; c++) begin
            cycle();
            m_ready = (stall && c <= 6) ? pat[c-1] : 1'b1;
            if (mid_start && c == 3) begin
                start      = 1'b1;
                start_addr = 3'd5;
                length     = 4'd2;
            end else begin
                start = 1'b0;
            end

            if (m_valid && prev_stall) begin
                check({tag, ".stall_data"}, 32'(m_data), 32'(prev_data));
                check({tag, ".stall_last"}, 32'(m_last), 32'(prev_last));
            end
            if (m_valid && m_ready) begin
                check({tag, ".data"}, 32'(m_data), 32'(((addr + got) % DEPTH) + 1));
                check({tag, ".last"}, 32'(m_last), 32'(got == n_exp - 1));
                if (!stall) check({tag, ".beat_cycle"}, 32'(c), 32'(got + 1));
                got++;
                last_acc = c;
            end
            if (done) begin
                done_cnt++;
                check({tag, ".done_cycle"}, 32'(c), 32'(last_acc + 1));
                check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
        start = 1'b0;
        check({tag, ".beats"},     32'(got),      32'(n_exp));
        check({tag, ".done_cnt"},  32'(done_cnt), 32'd1);
        check({tag, ".end_busy"},  32'(busy),     32'd0);
        check({tag, ".end_valid"}, 32'(m_valid),  32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        length     = '0;
        m_ready    = 1'b0;
        cycle();
        cycle();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        cycle();
        check_idle_outputs("post_reset");

        run_cmd("full8", 0, 8, 1'b0, 1'b0);
        run_cmd("wrap",  6, 4, 1'b0, 1'b0);
        run_cmd("stall", 2, 3, 1'b1, 1'b0);

        // Zero length: done only, no beats, busy never rises.
        start      = 1'b1;
        start_addr = 3'd4;
        length     = 4'd0;
        cycle();
        start = 1'b0;
        check("len0.done",  32'(done),    32'd1);
        check("len0.busy",  32'(busy),    32'd0);
        check("len0.valid", 32'(m_valid), 32'd0);
        cycle();
        check("len0.done_clear", 32'(done),    32'd0);
        check("len0.busy2",      32'(busy),    32'd0);
        check("len0.valid2",     32'(m_valid), 32'd0);

        run_cmd("sat9", 1, 9, 1'b0, 1'b1);

        // Reset in the middle of beat 3 of an 8-word command.
        start      = 1'b1;
        start_addr = 3'd0;
        length     = 4'd8;
        m_ready    = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        cycle();
        cycle();
        check("abort.pre_data", 32'(m_data), 32'd3);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        cycle();
        cycle();
        check("abort.no_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        cycle();
        check_idle_outputs("abort_release");

        run_cmd("fresh", 5, 3, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
